// File: rtl/scene_sequencer_if.sv
// Scene sequencer bus: VGA scan position, game events, the four per-scene
// pixel sources and the muxed display outputs. The sequencer takes the slave
// side; whatever drives the events and pixel sources takes the master side.
interface scene_sequencer_if;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        start_btn;
  logic        win_evt;
  logic        lose_evt;
  logic        sec_tick;
  logic [16:0] title_addr;
  logic [16:0] play_addr;
  logic [16:0] win_addr;
  logic [16:0] lose_addr;
  logic [11:0] title_data;
  logic [11:0] play_data;
  logic [11:0] win_data;
  logic [11:0] lose_data;
  logic [1:0]  scene;
  logic [16:0] pixel_addr;
  logic [11:0] vga_data;
  logic        game_en;
  logic [1:0]  reveal;

  modport master (
    output h_cnt, v_cnt, start_btn, win_evt, lose_evt, sec_tick,
    output title_addr, play_addr, win_addr, lose_addr,
    output title_data, play_data, win_data, lose_data,
    input  scene, pixel_addr, vga_data, game_en, reveal
  );

  modport slave (
    input  h_cnt, v_cnt, start_btn, win_evt, lose_evt, sec_tick,
    input  title_addr, play_addr, win_addr, lose_addr,
    input  title_data, play_data, win_data, lose_data,
    output scene, pixel_addr, vga_data, game_en, reveal
  );
endinterface

// File: rtl/scene_sequencer.sv
// Scene sequencer: steps TITLE -> PLAY -> WIN/LOSE -> TITLE. Requests are
// latched into a single pending slot and only applied at a frame boundary so
// the display never switches scene mid-frame. Also times the WIN/LOSE hold,
// paces the WIN text reveal, and muxes the active scene's pixel source.
module scene_sequencer #(
  parameter int HOLD_SEC      = 10,
  parameter int MIN_SEC       = 2,
  parameter int REVEAL_FRAMES = 30
) (
  input logic              clk,
  input logic              rst,
  scene_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    WIN   = 2'd2,
    LOSE  = 2'd3
  } scene_t;

  localparam int SEC_W   = (HOLD_SEC > 0) ? $clog2(HOLD_SEC + 1) : 1;
  localparam int FRAME_W = (REVEAL_FRAMES > 2) ? $clog2(REVEAL_FRAMES) : 1;

  localparam logic [SEC_W-1:0]   SEC_HOLD   = SEC_W'(HOLD_SEC);
  localparam logic [SEC_W-1:0]   SEC_MIN    = SEC_W'(MIN_SEC);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(REVEAL_FRAMES - 1);

  scene_t             scene_q;
  scene_t             pend_scene;
  scene_t             req_scene;
  logic               pend_valid;
  logic               req_valid;
  logic               frame_start;
  logic               in_result;
  logic [SEC_W-1:0]   sec_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [1:0]         reveal_q;
  logic               game_en_q;

  assign frame_start = (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0);
  assign in_result   = (scene_q == WIN) || (scene_q == LOSE);

  // Decode the request implied by this cycle's events; nothing new is taken while a request is pending
  always_comb begin
    req_valid = 1'b0;
    req_scene = TITLE;
    if (!pend_valid) begin
      case (scene_q)
        TITLE: begin
          if (bus.start_btn) begin
            req_valid = 1'b1;
            req_scene = PLAY;
          end
        end
        PLAY: begin
          if (bus.win_evt) begin
            req_valid = 1'b1;
            req_scene = WIN;
          end else if (bus.lose_evt) begin
            req_valid = 1'b1;
            req_scene = LOSE;
          end
        end
        default: begin
          if ((sec_cnt == SEC_HOLD) || (bus.start_btn && (sec_cnt >= SEC_MIN))) begin
            req_valid = 1'b1;
            req_scene = TITLE;
          end
        end
      endcase
    end
  end

  // Scene state: apply the pending request at frame start, otherwise latch requests and run the hold/reveal timers
  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q    <= TITLE;
      pend_valid <= 1'b0;
      pend_scene <= TITLE;
      sec_cnt    <= '0;
      frame_cnt  <= '0;
      reveal_q   <= 2'd0;
      game_en_q  <= 1'b0;
    end else if (frame_start && pend_valid) begin
      scene_q    <= pend_scene;
      pend_valid <= 1'b0;
      sec_cnt    <= '0;
      frame_cnt  <= '0;
      reveal_q   <= 2'd0;
      game_en_q  <= (pend_scene == PLAY);
    end else begin
      if (req_valid) begin
        pend_valid <= 1'b1;
        pend_scene <= req_scene;
      end
      if (in_result && bus.sec_tick && (sec_cnt != SEC_HOLD)) begin
        sec_cnt <= sec_cnt + SEC_W'(1);
      end
      if ((scene_q == WIN) && frame_start) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          if (reveal_q != 2'd3) begin
            reveal_q <= reveal_q + 2'd1;
          end
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

  // Route the active scene's pixel source to the shared memory address and the VGA output
  always_comb begin
    bus.pixel_addr = bus.title_addr;
    bus.vga_data   = bus.title_data;
    case (scene_q)
      PLAY: begin
        bus.pixel_addr = bus.play_addr;
        bus.vga_data   = bus.play_data;
      end
      WIN: begin
        bus.pixel_addr = bus.win_addr;
        bus.vga_data   = bus.win_data;
      end
      LOSE: begin
        bus.pixel_addr = bus.lose_addr;
        bus.vga_data   = bus.lose_data;
      end
      default: begin
        bus.pixel_addr = bus.title_addr;
        bus.vga_data   = bus.title_data;
      end
    endcase
  end

  assign bus.scene   = scene_q;
  assign bus.reveal  = reveal_q;
  assign bus.game_en = game_en_q;

endmodule
